// File: rtl/conv_kernel_ctrl.sv
// Kernel/divisor configuration controller for the 5x5 RGB convolution filter.
// Presets or a user bank are swapped into h/scale_down only at a frame boundary.
module conv_kernel_ctrl #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int N      = 25,
    parameter int COEF_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode_sel,
    input  logic                       cfg_we,
    input  logic [4:0]                 cfg_addr,
    input  logic [31:0]                cfg_wdata,
    input  logic                       cfg_commit,
    input  logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [N-1:0][COEF_W-1:0]   h,
    output logic [15:0]                scale_down,
    output logic [1:0]                 active_mode,
    output logic                       pending,
    output logic                       frame_end,
    output logic                       cfg_err
);

    localparam int PIX   = WIDTH * HEIGHT;
    localparam int CNT_W = (PIX > 1) ? $clog2(PIX) : 1;

    typedef logic [N-1:0][COEF_W-1:0] kernel_t;
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    // Taps are signed two's complement; 1024 is unity gain after the filter's >>10.
    function automatic kernel_t identity_k();
        kernel_t k;
        k = '0;
        k[N/2] = COEF_W'(1024);
        return k;
    endfunction

    function automatic int gauss_w(input int r, input int c);
        int rr, cc, lo, hi;
        rr = (r > 2) ? 4 - r : r;
        cc = (c > 2) ? 4 - c : c;
        lo = (rr < cc) ? rr : cc;
        hi = (rr < cc) ? cc : rr;
        case ({lo[1:0], hi[1:0]})
            4'b0000: return 1;
            4'b0001: return 4;
            4'b0010: return 7;
            4'b0101: return 16;
            4'b0110: return 26;
            4'b1010: return 41;
            default: return 0;
        endcase
    endfunction

    function automatic kernel_t gauss_k();
        kernel_t k;
        for (int i = 0; i < N; i++) k[i] = COEF_W'(gauss_w(i / 5, i % 5) * 1024);
        return k;
    endfunction

    function automatic kernel_t lap_k();
        kernel_t k;
        for (int i = 0; i < N; i++) k[i] = (i == N/2) ? COEF_W'(24 * 1024) : COEF_W'(-1024);
        return k;
    endfunction

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             hs;
    logic             commit_pend, commit_pend_nx;
    logic             commit_user;
    logic             swap;
    kernel_t          shadow_h, shadow_h_nx, stage_h, swap_h;
    logic [15:0]      shadow_sd, shadow_sd_nx, stage_sd, swap_sd;
    logic             err_set;

    // A pixel transfers on any cycle where pix_valid and pix_ready are both high;
    // neither side is assumed to wait for the other, and no handshake means the counter holds.
    assign hs          = pix_valid & pix_ready;
    assign frame_end   = hs && (cnt == CNT_W'(PIX - 1));
    assign pending     = (state == PENDING);
    assign commit_user = cfg_commit && (active_mode == 2'd3);

    // Shadow-bank update; same-cycle write is visible to a commit on this edge.
    always_comb begin
        shadow_h_nx  = shadow_h;
        shadow_sd_nx = shadow_sd;
        err_set      = 1'b0;
        if (cfg_we) begin
            if (cfg_addr < 5'(N)) begin
                shadow_h_nx[cfg_addr] = COEF_W'(cfg_wdata);
            end else if (cfg_addr == 5'(N)) begin
                shadow_sd_nx = (cfg_wdata[15:0] == 16'd0) ? 16'd1 : cfg_wdata[15:0];
                err_set      = (cfg_wdata[15:0] == 16'd0);
            end else begin
                err_set = 1'b1;
            end
        end
    end

    always_comb begin
        swap_h  = identity_k();
        swap_sd = 16'd1;
        case (mode_sel)
            2'd1: begin swap_h = gauss_k(); swap_sd = 16'd273; end
            2'd2: begin swap_h = lap_k();   swap_sd = 16'd1;   end
            2'd3: begin swap_h = stage_h;   swap_sd = stage_sd; end
            default: ;
        endcase
    end

    always_comb begin
        state_nx       = state;
        commit_pend_nx = commit_pend;
        swap           = 1'b0;
        case (state)
            IDLE: begin
                if (mode_sel != active_mode || commit_user) begin
                    state_nx       = PENDING;
                    commit_pend_nx = commit_user;
                end
            end
            PENDING: begin
                if (commit_user) commit_pend_nx = 1'b1;
                if (mode_sel == active_mode && !commit_pend && !commit_user) begin
                    state_nx       = IDLE;
                    commit_pend_nx = 1'b0;
                end else if (frame_end) begin
                    // A commit on the swap edge misses this swap and re-arms for the next frame.
                    swap           = 1'b1;
                    state_nx       = (cfg_commit && mode_sel == 2'd3) ? PENDING : IDLE;
                    commit_pend_nx = cfg_commit && (mode_sel == 2'd3);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            commit_pend <= 1'b0;
            cfg_err     <= 1'b0;
            shadow_h    <= identity_k();
            shadow_sd   <= 16'd1;
            stage_h     <= identity_k();
            stage_sd    <= 16'd1;
            h           <= identity_k();
            scale_down  <= 16'd1;
            active_mode <= 2'd0;
        end else begin
            state       <= state_nx;
            commit_pend <= commit_pend_nx;
            if (err_set) cfg_err <= 1'b1;
            if (hs) cnt <= frame_end ? '0 : cnt + 1'b1;
            shadow_h  <= shadow_h_nx;
            shadow_sd <= shadow_sd_nx;
            if (cfg_commit) begin
                stage_h  <= shadow_h_nx;
                stage_sd <= shadow_sd_nx;
            end
            if (swap) begin
                h           <= swap_h;
                scale_down  <= swap_sd;
                active_mode <= mode_sel;
            end
        end
    end

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Directed table-driven bench for conv_kernel_ctrl on a 4x3 frame.
module tb_conv_kernel_ctrl;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           mode_sel;
    logic                 cfg_we;
    logic [4:0]           cfg_addr;
    logic [31:0]          cfg_wdata;
    logic                 cfg_commit;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [24:0][31:0]    h;
    logic [15:0]          scale_down;
    logic [1:0]           active_mode;
    logic                 pending;
    logic                 frame_end;
    logic                 cfg_err;

    int checks   = 0;
    int failures = 0;

    conv_kernel_ctrl #(.WIDTH(4), .HEIGHT(3), .N(25), .COEF_W(32)) dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .h(h),
        .scale_down(scale_down), .active_mode(active_mode), .pending(pending),
        .frame_end(frame_end), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, r;
        logic [1:0]  ms;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        cm;
        logic        fe;
        logic [31:0] h12, h0;
        logic [15:0] sd;
        logic [1:0]  am;
        logic        pd, er;
    } vec_t;

    localparam logic [31:0] L0 = 32'hFFFF_FC00;
    vec_t vecs[$];

    function automatic vec_t mk(input logic v, r, input logic [1:0] ms, input logic we,
                                input logic [4:0] addr, input logic [31:0] wd, input logic cm,
                                input logic fe, input logic [31:0] h12, h0, input logic [15:0] sd,
                                input logic [1:0] am, input logic pd, er);
        vec_t x;
        x.v = v; x.r = r; x.ms = ms; x.we = we; x.addr = addr; x.wd = wd; x.cm = cm;
        x.fe = fe; x.h12 = h12; x.h0 = h0; x.sd = sd; x.am = am; x.pd = pd; x.er = er;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        pix_valid = x.v; pix_ready = x.r; mode_sel = x.ms; cfg_we = x.we;
        cfg_addr = x.addr; cfg_wdata = x.wd; cfg_commit = x.cm;
        #2;
        chk({tag, "_frame_end"}, {31'd0, frame_end}, {31'd0, x.fe});
        @(posedge clk);
        #1;
        chk({tag, "_h12"}, h[12], x.h12);
        chk({tag, "_h0"}, h[0], x.h0);
        chk({tag, "_scale_down"}, {16'd0, scale_down}, {16'd0, x.sd});
        chk({tag, "_active_mode"}, {30'd0, active_mode}, {30'd0, x.am});
        chk({tag, "_pending"}, {31'd0, pending}, {31'd0, x.pd});
        chk({tag, "_cfg_err"}, {31'd0, cfg_err}, {31'd0, x.er});
    endtask

    // kind: 0 identity, 1 gaussian, 2 laplacian, 3 uniform 2048
    task automatic check_kernel(input int kind, input string tag);
        int g[25] = '{1,4,7,4,1, 4,16,26,16,4, 7,26,41,26,7, 4,16,26,16,4, 1,4,7,4,1};
        logic [31:0] e;
        for (int i = 0; i < 25; i++) begin
            case (kind)
                0: e = (i == 12) ? 32'd1024 : 32'd0;
                1: e = 32'(g[i] * 1024);
                2: e = (i == 12) ? 32'd24576 : L0;
                default: e = 32'd2048;
            endcase
            chk($sformatf("%s_tap%0d", tag, i), h[i], e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pix_valid = 1'b0; pix_ready = 1'b1; mode_sel = 2'd0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_ready = 1'b0; mode_sel = 2'd0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;

        // Frame A: identity, wrap on the 12th handshake
        for (int k = 0; k < 11; k++) vecs.push_back(mk(1,1,0,0,0,0,0, 0, 1024,0,1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1, 1024,0,1,0,0,0));
        // Frame B: request gaussian at pixel 5, stall 20 cycles, swap at frame end
        for (int k = 0; k < 5; k++) vecs.push_back(mk(1,1,0,0,0,0,0, 0, 1024,0,1,0,0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 0, 1024,0,1,0,1,0));
        for (int k = 0; k < 20; k++) vecs.push_back(mk(0,1,1,0,0,0,0, 0, 1024,0,1,0,1,0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(1,1,1,0,0,0,0, 0, 1024,0,1,0,1,0));
        vecs.push_back(mk(1,1,1,0,0,0,0, 1, 41984,1024,273,1,0,0));

        do_reset();
        chk("reset_scale_down", {16'd0, scale_down}, 32'd1);
        chk("reset_pending", {31'd0, pending}, 32'd0);
        check_kernel(0, "reset");
        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));
        check_kernel(1, "gauss");
        vecs.delete();

        // User bank: all taps 2048, divisor 50, commit with mode 3, swap at frame C end
        for (int k = 0; k < 25; k++)
            vecs.push_back(mk(0,1,1,1,5'(k),2048,0, 0, 41984,1024,273,1,0,0));
        vecs.push_back(mk(0,1,1,1,25,50,0, 0, 41984,1024,273,1,0,0));
        vecs.push_back(mk(0,1,3,0,0,0,1, 0, 41984,1024,273,1,1,0));
        for (int k = 0; k < 11; k++) vecs.push_back(mk(1,1,3,0,0,0,0, 0, 41984,1024,273,1,1,0));
        vecs.push_back(mk(1,1,3,0,0,0,0, 1, 2048,2048,50,3,0,0));
        foreach (vecs[i]) apply(vecs[i], $sformatf("u%0d", i));
        check_kernel(3, "user");
        vecs.delete();

        // scale_down write of 0; uncommitted tap write; commit on frame_end edge
        vecs.push_back(mk(0,1,3,1,25,0,0, 0, 2048,2048,50,3,0,1));
        vecs.push_back(mk(0,1,3,1,12,0,0, 0, 2048,2048,50,3,0,1));
        for (int k = 0; k < 11; k++) vecs.push_back(mk(1,1,3,0,0,0,0, 0, 2048,2048,50,3,0,1));
        vecs.push_back(mk(1,1,3,0,0,0,0, 1, 2048,2048,50,3,0,1));
        for (int k = 0; k < 11; k++) vecs.push_back(mk(1,1,3,0,0,0,0, 0, 2048,2048,50,3,0,1));
        vecs.push_back(mk(1,1,3,0,0,0,1, 1, 2048,2048,50,3,1,1));
        for (int k = 0; k < 11; k++) vecs.push_back(mk(1,1,3,0,0,0,0, 0, 2048,2048,50,3,1,1));
        vecs.push_back(mk(1,1,3,0,0,0,0, 1, 0,2048,1,3,0,1));
        // Request laplacian then withdraw before frame end
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1,1,3,0,0,0,0, 0, 0,2048,1,3,0,1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1,1,2,0,0,0,0, 0, 0,2048,1,3,1,1));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(1,1,3,0,0,0,0, 0, 0,2048,1,3,0,1));
        vecs.push_back(mk(1,1,3,0,0,0,0, 1, 0,2048,1,3,0,1));
        // Laplacian for a whole frame
        for (int k = 0; k < 11; k++) vecs.push_back(mk(1,1,2,0,0,0,0, 0, 0,2048,1,3,1,1));
        vecs.push_back(mk(1,1,2,0,0,0,0, 1, 24576,L0,1,2,0,1));
        foreach (vecs[i]) apply(vecs[i], $sformatf("w%0d", i));
        check_kernel(2, "lap");

        // Mid-frame reset: 5 pixels in, then everything back to reset values
        for (int k = 0; k < 5; k++)
            apply(mk(1,1,2,0,0,0,0, 0, 24576,L0,1,2,0,1), $sformatf("pre%0d", k));
        do_reset();
        chk("mreset_h12", h[12], 32'd1024);
        chk("mreset_h0", h[0], 32'd0);
        chk("mreset_scale_down", {16'd0, scale_down}, 32'd1);
        chk("mreset_active_mode", {30'd0, active_mode}, 32'd0);
        chk("mreset_pending", {31'd0, pending}, 32'd0);
        chk("mreset_cfg_err", {31'd0, cfg_err}, 32'd0);
        for (int k = 0; k < 11; k++)
            apply(mk(1,1,0,0,0,0,0, 0, 1024,0,1,0,0,0), $sformatf("post%0d", k));
        apply(mk(1,1,0,0,0,0,0, 1, 1024,0,1,0,0,0), "post_last");
        apply(mk(0,1,0,1,26,5,0, 0, 1024,0,1,0,0,1), "bad_addr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
